// File: rtl/sum_acc_pkg.sv
// Shared types and defaults for the sum accumulator slice.
// Width helpers keep the counter sized to hold COUNT itself.
package sum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int IN_W_DEF  = 5;
  localparam int COUNT_DEF = 4;
  localparam int ACC_W_DEF = 7;

  function automatic int cnt_w(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// Input sample stream and output total stream of the sum accumulator.
// The slave side is the accumulator; the master side feeds and drains it.
interface sum_accumulator_if
  import sum_acc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int COUNT = COUNT_DEF,
  parameter int ACC_W = ACC_W_DEF
);
  localparam int CW = cnt_w(COUNT);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  sum_in;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] total;
  logic             ovf;
  logic [CW-1:0]    cnt;

  modport slave (
    input  in_valid, sum_in, out_ready,
    output in_ready, out_valid, total, ovf, cnt
  );

  modport master (
    output in_valid, sum_in, out_ready,
    input  in_ready, out_valid, total, ovf, cnt
  );
endinterface

// File: rtl/sum_accumulator_sat_add.sv
// Unsigned saturating adder: y = min(a + b, 2^ACC_W - 1), ovf flags clamping.
// Purely combinational; b is zero-extended into a one-bit-wider sum.
module sat_add #(
  parameter int ACC_W = 7,
  parameter int IN_W  = 5
) (
  input  logic [ACC_W-1:0] a,
  input  logic [IN_W-1:0]  b,
  output logic [ACC_W-1:0] y,
  output logic             ovf
);
  logic [ACC_W:0] sum_wide;

  always_comb begin
    sum_wide = {1'b0, a} + {{(ACC_W + 1 - IN_W){1'b0}}, b};
    ovf      = sum_wide[ACC_W];
    y        = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  end
endmodule

// File: rtl/sum_accumulator.sv
// Collects COUNT adder results into a saturating total with sticky overflow,
// then holds the total on a valid/ready output until it is taken.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int COUNT = COUNT_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  sum_accumulator_if.slave  bus
);
  localparam int            CW      = cnt_w(COUNT);
  localparam logic [CW-1:0] COUNT_C = CW'(COUNT);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;

  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_y;
  logic             add_ovf;
  logic [CW-1:0]    cnt_inc;

  // Starting a burst adds onto zero, so IDLE and ACCUM share one adder.
  assign add_a   = (state_reg == ACCUM) ? acc_reg : '0;
  assign cnt_inc = cnt_reg + ONE_C;

  sat_add #(
    .ACC_W (ACC_W),
    .IN_W  (IN_W)
  ) u_sat_add (
    .a   (add_a),
    .b   (bus.sum_in),
    .y   (add_y),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    // Clear outranks both handshakes, so it is decoded before the state.
    if (clr) begin
      state_next = IDLE;
      acc_next   = '0;
      cnt_next   = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            state_next = ACCUM;
            acc_next   = add_y;
            cnt_next   = ONE_C;
            ovf_next   = 1'b0;
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            acc_next = add_y;
            cnt_next = cnt_inc;
            ovf_next = ovf_reg | add_ovf;
            if (cnt_inc == COUNT_C) state_next = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
          end
        end
        default: begin
          state_next = IDLE;
          acc_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = rst_n && (state_reg != DONE);
    bus.out_valid = (state_reg == DONE);
    bus.total     = acc_reg;
    bus.ovf       = ovf_reg;
    bus.cnt       = cnt_reg;
  end
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a default-width instance and a
// 6-bit accumulator instance that exercises saturation.
module tb_sum_accumulator;
  import sum_acc_pkg::*;

  logic clk;
  logic rst_n;
  logic clr0;
  logic clr1;
  int   tests;
  int   fails;

  sum_accumulator_if #(.IN_W(5), .COUNT(4), .ACC_W(7)) if0 ();
  sum_accumulator_if #(.IN_W(5), .COUNT(4), .ACC_W(6)) if1 ();

  sum_accumulator #(.IN_W(5), .COUNT(4), .ACC_W(7)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr0),
    .bus   (if0.slave)
  );

  sum_accumulator #(.IN_W(5), .COUNT(4), .ACC_W(6)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr1),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("[TB] %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One accepted sample on dut0, then check the running count and total.
  task automatic push0(input logic [4:0] v, input int exp_cnt, input int exp_tot, input string tag);
    if0.in_valid = 1'b1;
    if0.sum_in   = v;
    tick();
    chk({tag, ".cnt"}, 32'(if0.cnt), 32'(exp_cnt));
    chk({tag, ".total"}, 32'(if0.total), 32'(exp_tot));
  endtask

  task automatic push1(input logic [4:0] v, input int exp_tot, input int exp_ovf, input string tag);
    if1.in_valid = 1'b1;
    if1.sum_in   = v;
    tick();
    chk({tag, ".total"}, 32'(if1.total), 32'(exp_tot));
    chk({tag, ".ovf"}, 32'(if1.ovf), 32'(exp_ovf));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    clr0  = 1'b0;
    clr1  = 1'b0;
    if0.in_valid = 1'b0; if0.sum_in = '0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.sum_in = '0; if1.out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst.in_ready", 32'(if0.in_ready), 0);
    chk("rst.out_valid", 32'(if0.out_valid), 0);
    chk("rst.total", 32'(if0.total), 0);
    chk("rst.cnt", 32'(if0.cnt), 0);
    chk("rst.ovf", 32'(if0.ovf), 0);
    #10 rst_n = 1'b1;
    tick();
    chk("rel.in_ready", 32'(if0.in_ready), 1);

    // Burst 0,2,4,10 back-to-back, output always ready
    if0.out_ready = 1'b1;
    push0(5'd0, 1, 0, "b1.s1");
    push0(5'd2, 2, 2, "b1.s2");
    push0(5'd4, 3, 6, "b1.s3");
    chk("b1.s3.out_valid", 32'(if0.out_valid), 0);
    push0(5'd10, 4, 16, "b1.s4");
    if0.in_valid = 1'b0;
    chk("b1.out_valid", 32'(if0.out_valid), 1);
    chk("b1.ovf", 32'(if0.ovf), 0);
    chk("b1.in_ready_low", 32'(if0.in_ready), 0);
    tick();
    chk("b1.post.out_valid", 32'(if0.out_valid), 0);
    chk("b1.post.in_ready", 32'(if0.in_ready), 1);
    chk("b1.post.total", 32'(if0.total), 0);

    // Burst 2,22,gap,31,1 with a 5-cycle output stall
    if0.out_ready = 1'b0;
    push0(5'd2, 1, 2, "b2.s1");
    push0(5'd22, 2, 24, "b2.s2");
    if0.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2.gap.cnt", 32'(if0.cnt), 2);
      chk("b2.gap.total", 32'(if0.total), 24);
    end
    push0(5'd31, 3, 55, "b2.s3");
    push0(5'd1, 4, 56, "b2.s4");
    if0.sum_in = 5'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b2.stall.out_valid", 32'(if0.out_valid), 1);
      chk("b2.stall.total", 32'(if0.total), 56);
      chk("b2.stall.in_ready", 32'(if0.in_ready), 0);
    end
    if0.in_valid  = 1'b0;
    if0.out_ready = 1'b1;
    tick();
    chk("b2.post.out_valid", 32'(if0.out_valid), 0);

    // Saturation on the 6-bit instance
    if1.out_ready = 1'b1;
    push1(5'd31, 31, 0, "sat.s1");
    push1(5'd31, 62, 0, "sat.s2");
    push1(5'd31, 63, 1, "sat.s3");
    push1(5'd31, 63, 1, "sat.s4");
    if1.in_valid = 1'b0;
    chk("sat.out_valid", 32'(if1.out_valid), 1);
    tick();
    chk("sat.post.ovf", 32'(if1.ovf), 0);
    push1(5'd1, 1, 0, "sat2.s1");
    push1(5'd1, 2, 0, "sat2.s2");
    push1(5'd1, 3, 0, "sat2.s3");
    push1(5'd1, 4, 0, "sat2.s4");
    if1.in_valid = 1'b0;
    chk("sat2.out_valid", 32'(if1.out_valid), 1);
    tick();

    // Clear with a concurrent valid sample
    push0(5'd5, 1, 5, "clr.s1");
    push0(5'd7, 2, 12, "clr.s2");
    clr0 = 1'b1;
    if0.sum_in = 5'd3;
    tick();
    clr0 = 1'b0;
    if0.in_valid = 1'b0;
    chk("clr.cnt", 32'(if0.cnt), 0);
    chk("clr.total", 32'(if0.total), 0);
    chk("clr.in_ready", 32'(if0.in_ready), 1);
    push0(5'd1, 1, 1, "clr2.s1");
    push0(5'd1, 2, 2, "clr2.s2");
    push0(5'd1, 3, 3, "clr2.s3");
    push0(5'd1, 4, 4, "clr2.s4");
    if0.in_valid = 1'b0;
    chk("clr2.out_valid", 32'(if0.out_valid), 1);
    tick();

    // Asynchronous reset between clock edges mid-burst
    push0(5'd10, 1, 10, "ar.s1");
    push0(5'd10, 2, 20, "ar.s2");
    if0.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar.cnt", 32'(if0.cnt), 0);
    chk("ar.total", 32'(if0.total), 0);
    chk("ar.in_ready", 32'(if0.in_ready), 0);
    chk("ar.out_valid", 32'(if0.out_valid), 0);
    #1 rst_n = 1'b1;
    tick();
    push0(5'd3, 1, 3, "ar2.s1");
    push0(5'd3, 2, 6, "ar2.s2");
    push0(5'd3, 3, 9, "ar2.s3");
    push0(5'd3, 4, 12, "ar2.s4");
    if0.in_valid = 1'b0;
    chk("ar2.out_valid", 32'(if0.out_valid), 1);
    tick();

    // Handshake in DONE with in_valid held high throughout
    if0.out_ready = 1'b0;
    push0(5'd1, 1, 1, "hs.s1");
    push0(5'd2, 2, 3, "hs.s2");
    push0(5'd3, 3, 6, "hs.s3");
    push0(5'd4, 4, 10, "hs.s4");
    if0.sum_in    = 5'd5;
    if0.out_ready = 1'b1;
    tick();
    chk("hs.idle.cnt", 32'(if0.cnt), 0);
    chk("hs.idle.in_ready", 32'(if0.in_ready), 1);
    chk("hs.idle.out_valid", 32'(if0.out_valid), 0);
    tick();
    chk("hs.n1.cnt", 32'(if0.cnt), 1);
    chk("hs.n1.total", 32'(if0.total), 5);
    tick();
    chk("hs.n2.cnt", 32'(if0.cnt), 2);
    chk("hs.n2.total", 32'(if0.total), 10);
    if0.in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
